// File: rtl/ttl_quad2_gate_exerciser.sv
// ttl_quad2_gate_exerciser: walks a quad 2-input gate through its truth table and reports pass or the first failing gate
module ttl_quad2_gate_exerciser #(
  parameter int SETTLE_CYCLES = 16,
  parameter logic [3:0] TRUTH = 4'b0001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  input  logic [3:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] fail_gate,
  output logic [1:0] fail_step,
  output logic [1:0] fail_vec,
  output logic       fail_y
);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE, FAIL} state_t;
  state_t     state_q;
  logic [7:0] cnt_q;
  logic [1:0] step_q;
  logic [3:0] sync1_q, sync2_q;
  logic [1:0] v_d [4];
  logic [3:0] a_d, b_d, exp_d, mis_d;
  logic [1:0] gate_d, vec_d;
  // Per-gate vector for the current step, expected nibble and lowest mismatching gate
  always_comb begin
    a_d = '0;
    b_d = '0;
    exp_d = '0;
    gate_d = '0;
    for (int i = 0; i < 4; i++) begin
      v_d[i] = step_q + 2'(i);
      a_d[i] = v_d[i][0];
      b_d[i] = v_d[i][1];
      exp_d[i] = TRUTH[v_d[i]];
    end
    mis_d = exp_d ^ sync2_q;
    for (int i = 3; i >= 0; i--) gate_d = mis_d[i] ? 2'(i) : gate_d;
    vec_d = step_q + gate_d;
  end
  // Run sequencer with registered status, plus the two-flop synchronizer on y_in
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      step_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      a_out <= '0;
      b_out <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      fail <= 1'b0;
      fail_gate <= '0;
      fail_step <= '0;
      fail_vec <= '0;
      fail_y <= 1'b0;
    end else begin
      sync1_q <= y_in;
      sync2_q <= sync1_q;
      case (state_q)
        IDLE, DONE, FAIL: begin
          if (start) begin
            state_q <= DRIVE;
            step_q <= '0;
            busy <= 1'b1;
            done <= 1'b0;
            fail <= 1'b0;
            fail_gate <= '0;
            fail_step <= '0;
            fail_vec <= '0;
            fail_y <= 1'b0;
          end else begin
            busy <= 1'b0;
            done <= state_q == DONE;
            fail <= state_q == FAIL;
          end
        end
        DRIVE: begin
          a_out <= a_d;
          b_out <= b_d;
          cnt_q <= '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          cnt_q <= cnt_q + 8'd1;
          state_q <= cnt_q == 8'(SETTLE_CYCLES - 1) ? CHECK : SETTLE;
        end
        CHECK: begin
          if (|mis_d) begin
            state_q <= FAIL;
            fail_gate <= gate_d;
            fail_step <= step_q;
            fail_vec <= vec_d;
            fail_y <= sync2_q[gate_d];
          end else if (step_q == 2'd3) begin
            state_q <= DONE;
          end else begin
            step_q <= step_q + 2'd1;
            state_q <= DRIVE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
